// File: rtl/reaction_ctrl.sv
// Reaction-time game sequencer: random foreperiod, cue LED, then a millisecond
// reaction measurement with early-press and timeout detection.
module reaction_ctrl #(
  parameter int unsigned CLKS_PER_MS  = 50000,
  parameter int unsigned MIN_DELAY_MS = 1000,
  parameter int unsigned RAND_W       = 10,
  parameter int unsigned TIMEOUT_MS   = 2000,
  parameter int unsigned CNT_W        = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             button,
  output logic             led_on,
  output logic             busy,
  output logic             result_valid,
  output logic [CNT_W-1:0] reaction_ms,
  output logic             too_early,
  output logic             timed_out
);

  localparam int unsigned PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [PW-1:0]    PresLast    = PW'(CLKS_PER_MS - 1);
  localparam logic [CNT_W-1:0] MinDelay    = CNT_W'(MIN_DELAY_MS);
  localparam logic [CNT_W-1:0] TimeoutMs   = CNT_W'(TIMEOUT_MS);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_MS - 1);
  localparam logic [CNT_W-1:0] CntOne      = CNT_W'(1);

  typedef enum logic [1:0] {StIdle, StDelay, StMeasure, StDone} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [CNT_W-1:0] ms_cnt_q, ms_cnt_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic             led_on_q, led_on_d;
  logic             busy_q, busy_d;
  logic             result_valid_q, result_valid_d;
  logic [CNT_W-1:0] reaction_ms_q, reaction_ms_d;
  logic             too_early_q, too_early_d;
  logic             timed_out_q, timed_out_d;
  logic             ms_tick;
  logic             lfsr_fb;

  assign ms_tick = (presc_q == PresLast);
  // Right-shifting Fibonacci form of taps 16,14,13,11.
  assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

  always_comb begin
    state_d        = state_q;
    presc_d        = presc_q;
    ms_cnt_d       = ms_cnt_q;
    target_d       = target_q;
    reaction_ms_d  = reaction_ms_q;
    too_early_d    = too_early_q;
    timed_out_d    = timed_out_q;
    lfsr_d         = {lfsr_fb, lfsr_q[15:1]};

    unique case (state_q)
      StIdle: begin
        if (start && !button) begin
          state_d  = StDelay;
          target_d = MinDelay + CNT_W'(lfsr_q[RAND_W-1:0]);
        end
      end
      StDelay: begin
        if (button) begin
          state_d       = StDone;
          reaction_ms_d = '0;
          too_early_d   = 1'b1;
          timed_out_d   = 1'b0;
        end else if (ms_tick && (ms_cnt_q == target_q - CntOne)) begin
          state_d = StMeasure;
        end
      end
      StMeasure: begin
        // A press in the timeout cycle still counts as a valid reaction.
        if (button) begin
          state_d       = StDone;
          reaction_ms_d = ms_cnt_q;
          too_early_d   = 1'b0;
          timed_out_d   = 1'b0;
        end else if (ms_tick && (ms_cnt_q == TimeoutLast)) begin
          state_d       = StDone;
          reaction_ms_d = TimeoutMs;
          too_early_d   = 1'b0;
          timed_out_d   = 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Timebase restarts on every state entry and only runs while a round is live.
    if (state_d != state_q) begin
      presc_d  = '0;
      ms_cnt_d = '0;
    end else if ((state_q == StDelay) || (state_q == StMeasure)) begin
      if (ms_tick) begin
        presc_d  = '0;
        ms_cnt_d = ms_cnt_q + CntOne;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end

    led_on_d       = (state_d == StMeasure);
    busy_d         = (state_d == StDelay) || (state_d == StMeasure);
    result_valid_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      presc_q        <= '0;
      ms_cnt_q       <= '0;
      target_q       <= '0;
      lfsr_q         <= 16'hACE1;
      led_on_q       <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      reaction_ms_q  <= '0;
      too_early_q    <= 1'b0;
      timed_out_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      presc_q        <= presc_d;
      ms_cnt_q       <= ms_cnt_d;
      target_q       <= target_d;
      lfsr_q         <= lfsr_d;
      led_on_q       <= led_on_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
      reaction_ms_q  <= reaction_ms_d;
      too_early_q    <= too_early_d;
      timed_out_q    <= timed_out_d;
    end
  end

  assign led_on       = led_on_q;
  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign reaction_ms  = reaction_ms_q;
  assign too_early    = too_early_q;
  assign timed_out    = timed_out_q;

endmodule

// File: tb/tb_reaction_ctrl.sv
// Bench for reaction_ctrl with small timing parameters; expected timing is
// derived arithmetically from the target delay, press time and timeout.
module tb_reaction_ctrl;

  localparam int CLKS = 4;
  localparam int MIND = 2;
  localparam int RW   = 2;
  localparam int TO   = 8;
  localparam int CW   = 14;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          button;
  logic          led_on;
  logic          busy;
  logic          result_valid;
  logic [CW-1:0] reaction_ms;
  logic          too_early;
  logic          timed_out;

  int n_tests = 0;
  int n_fail  = 0;

  // Last reported result, expected to hold between rounds.
  int exp_rm = 0;
  bit exp_te = 1'b0;
  bit exp_to = 1'b0;

  logic [15:0] lfsr_m;

  always #5 clk = ~clk;

  reaction_ctrl #(
    .CLKS_PER_MS (CLKS),
    .MIN_DELAY_MS(MIND),
    .RAND_W      (RW),
    .TIMEOUT_MS  (TO),
    .CNT_W       (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .button      (button),
    .led_on      (led_on),
    .busy        (busy),
    .result_valid(result_valid),
    .reaction_ms (reaction_ms),
    .too_early   (too_early),
    .timed_out   (timed_out)
  );

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    logic [15:0] fb;
    fb = ((v >> 0) ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 16'h0001;
    return (v >> 1) | (fb << 15);
  endfunction

  always @(posedge clk) lfsr_m <= reset ? 16'hACE1 : lfsr_next(lfsr_m);

  task automatic step();
    @(negedge clk);
  endtask

  // Issues start at a negedge; returns the foreperiod in ms the DUT should latch.
  task automatic begin_round(output int t);
    t = MIND + (int'(lfsr_m) % (1 << RW));
    start = 1'b1;
    step();
    start = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || led_on !== 1'b0) begin
      n_fail++;
      $display("FAIL start_busy: busy=%b led_on=%b, required busy=1 led_on=0", busy, led_on);
    end
    n_tests++;
    if (int'(reaction_ms) != exp_rm || too_early !== exp_te || timed_out !== exp_to) begin
      n_fail++;
      $display("FAIL result_hold: rm=%0d te=%b to=%b, required rm=%0d te=%b to=%b",
               reaction_ms, too_early, timed_out, exp_rm, exp_te, exp_to);
    end
  endtask

  // Counts DELAY cycles until the LED lights; optionally pulses start meanwhile.
  task automatic wait_led(input int t, input bit poke_start);
    int cnt;
    cnt = 0;
    while (led_on !== 1'b1 && cnt < t * CLKS + 8) begin
      start = poke_start && (cnt % 3 == 1);
      step();
      cnt++;
    end
    start = 1'b0;
    n_tests++;
    if (cnt != t * CLKS) begin
      n_fail++;
      $display("FAIL led_delay: led rose after %0d cycles, required %0d (t=%0d)", cnt, t * CLKS, t);
    end
  endtask

  // From the first MEASURE cycle: press in MEASURE cycle k (k beyond the window = no press).
  task automatic finish_measure(input int k);
    int erm;
    bit eto;
    for (int m = 0; m < TO * CLKS; m++) begin
      if (m == k) button = 1'b1;
      step();
      if (button) break;
    end
    eto = (k >= TO * CLKS);
    erm = eto ? TO : k / CLKS;
    n_tests++;
    if (result_valid !== 1'b1 || int'(reaction_ms) != erm || timed_out !== eto ||
        too_early !== 1'b0) begin
      n_fail++;
      $display("FAIL measure_result k=%0d: rv=%b rm=%0d to=%b te=%b, required rv=1 rm=%0d to=%b te=0",
               k, result_valid, reaction_ms, timed_out, too_early, erm, eto);
    end
    n_tests++;
    if (led_on !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_outputs: led_on=%b busy=%b, required 0 0", led_on, busy);
    end
    exp_rm = erm;
    exp_te = 1'b0;
    exp_to = eto;
    button = 1'b0;
    step();
    start = 1'b0;
    n_tests++;
    if (result_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_one_cycle: rv=%b busy=%b, required 0 0", result_valid, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    button = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();
    n_tests++;
    if (led_on !== 1'b0 || busy !== 1'b0 || result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: led=%b busy=%b rv=%b, required 0 0 0", led_on, busy, result_valid);
    end
    n_tests++;
    if (reaction_ms !== '0 || too_early !== 1'b0 || timed_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_result: rm=%0d te=%b to=%b, required 0 0 0",
               reaction_ms, too_early, timed_out);
    end
  endtask

  task automatic test_normal();
    int t;
    begin_round(t);
    wait_led(t, 1'b0);
    finish_measure(13);
  endtask

  task automatic test_mid_reset();
    int t;
    bit seen_rv;
    begin_round(t);
    repeat (3) step();
    reset = 1'b1;
    seen_rv = 1'b0;
    repeat (3) begin
      step();
      seen_rv |= result_valid;
    end
    reset = 1'b0;
    step();
    seen_rv |= result_valid;
    exp_rm = 0;
    exp_te = 1'b0;
    exp_to = 1'b0;
    n_tests++;
    if (seen_rv || led_on !== 1'b0 || busy !== 1'b0 || reaction_ms !== '0 ||
        too_early !== 1'b0 || timed_out !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: rv_seen=%b led=%b busy=%b rm=%0d te=%b to=%b, required all 0",
               seen_rv, led_on, busy, reaction_ms, too_early, timed_out);
    end
  endtask

  // d < 0 selects the DELAY expiry cycle; otherwise d is folded into the DELAY window.
  task automatic test_early(input int d);
    int t;
    int dd;
    bit led_seen;
    begin_round(t);
    dd = (d < 0) ? t * CLKS - 1 : d % (t * CLKS);
    led_seen = 1'b0;
    for (int i = 0; i < dd; i++) begin
      step();
      led_seen |= led_on;
    end
    button = 1'b1;
    step();
    n_tests++;
    if (result_valid !== 1'b1 || too_early !== 1'b1 || timed_out !== 1'b0 ||
        reaction_ms !== '0 || led_on !== 1'b0 || led_seen || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL early_press d=%0d: rv=%b te=%b to=%b rm=%0d led=%b/%b busy=%b, required 1 1 0 0 0/0 0",
               dd, result_valid, too_early, timed_out, reaction_ms, led_on, led_seen, busy);
    end
    exp_rm = 0;
    exp_te = 1'b1;
    exp_to = 1'b0;
    button = 1'b0;
    step();
    n_tests++;
    if (result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL early_one_cycle: rv=%b, required 0", result_valid);
    end
  endtask

  task automatic test_timeout();
    int t;
    begin_round(t);
    wait_led(t, 1'b0);
    finish_measure(1000);
  endtask

  task automatic test_simultaneous();
    int t;
    test_early(-1);
    begin_round(t);
    wait_led(t, 1'b0);
    finish_measure(TO * CLKS - 1);
  endtask

  task automatic test_ignored_starts();
    int t;
    button = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    button = 1'b0;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_with_button: busy=%b, required 0", busy);
    end
    step();
    begin_round(t);
    wait_led(t, 1'b1);
    // start held through MEASURE and DONE must have no effect.
    start = 1'b1;
    finish_measure(6);
  endtask

  task automatic test_random();
    int t;
    int k;
    repeat (14) begin
      repeat ($urandom_range(0, 6)) step();
      if ($urandom_range(0, 3) == 0) begin
        test_early(int'($urandom_range(0, 40)));
      end else begin
        begin_round(t);
        wait_led(t, 1'b0);
        k = int'($urandom_range(0, TO * CLKS + 4));
        finish_measure(k);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_normal();
    test_mid_reset();
    test_early(3);
    test_timeout();
    test_simultaneous();
    test_ignored_starts();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
